clock_period_meter: RTL and testbench

Measures the period and high time of a slow, asynchronous periodic input, counted in `clkin` cycles. It is the receiving end of the clock divider: it reads a divided or external clock (divider output, codec bit clock, LR clock) and reports its period, duty and stability. Outputs feed audio-path sanity checks and the status LEDs.

---
 rtl/clk_meas_pkg.sv | 13 +
 rtl/clock_period_meter_sync_edge.sv | 32 +++
 rtl/clock_period_meter.sv | 165 ++++++++++++++++
 tb/tb_clock_period_meter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/clk_meas_pkg.sv
// rtl/clk_meas_pkg.sv - shared state encoding and default sizing for clock_period_meter
package clk_meas_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int TOL_DEF    = 1;
  localparam int LOCK_N_DEF = 4;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/clock_period_meter_sync_edge.sv
// rtl/clock_period_meter_sync_edge.sv - 2-FF synchronizer with edge detection for the measured signal
module sync_edge (
  input  logic clkin,
  input  logic rst,
  input  logic sigin,
  output logic s2,
  output logic rise,
  output logic fall
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Two flops absorb metastability; the third holds the previous settled value for edge detection.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sigin;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2   = s2_q;
  assign rise = s2_q & ~s3_q;
  assign fall = ~s2_q & s3_q;

endmodule

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period, high time and stability of a slow asynchronous input
module clock_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TOL    = TOL_DEF,
  parameter int LOCK_N = LOCK_N_DEF
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             sigin,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_W   = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_W  = MW'(LOCK_N);

  logic s2;
  logic rise;
  logic fall_unused;

  sync_edge u_sync (
    .clkin (clkin),
    .rst   (rst),
    .sigin (sigin),
    .s2    (s2),
    .rise  (rise),
    .fall  (fall_unused)
  );

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] hcnt_q,   hcnt_d;
  logic [CNT_W-1:0] ref_q,    ref_d;
  logic [MW-1:0]    mcnt_q,   mcnt_d;
  logic             first_q,  first_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q,   high_d;
  logic             valid_q,  valid_d;
  logic             locked_q, locked_d;
  logic             tmo_q,    tmo_d;

  logic [CNT_W-1:0] diff;

  // Distance between the period just completed and the previous one.
  always_comb begin
    diff = '0;
    if (cnt_q >= ref_q) begin
      diff = cnt_q - ref_q;
    end else begin
      diff = ref_q - cnt_q;
    end
  end

  // State, counters and output registers; every output clears immediately on reset.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      ref_q    <= '0;
      mcnt_q   <= '0;
      first_q  <= 1'b0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      ref_q    <= ref_d;
      mcnt_q   <= mcnt_d;
      first_q  <= first_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state: wait for a first edge, then count between edges, publish, and track lock.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    ref_d    = ref_q;
    mcnt_d   = mcnt_q;
    first_d  = first_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    locked_d = locked_q;
    tmo_d    = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          tmo_d   = 1'b0;
          first_d = 1'b1;
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        if (rise) begin
          // An edge arriving together with a full counter is still a valid measurement.
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
          ref_d    = cnt_q;
          if (first_q) begin
            mcnt_d  = '0;
            first_d = 1'b0;
          end else if (diff <= TOL_W) begin
            if (mcnt_q != LOCK_W) begin
              mcnt_d = mcnt_q + MW'(1);
            end
            if (mcnt_d == LOCK_W) begin
              locked_d = 1'b1;
            end
          end else begin
            mcnt_d   = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == CNT_MAX) begin
          // Counter is full with no edge: give up rather than wrap and report garbage.
          tmo_d    = 1'b1;
          locked_d = 1'b0;
          mcnt_d   = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (s2) begin
            hcnt_d = hcnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = tmo_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed self-checking bench for clock_period_meter
module tb_clock_period_meter;

  localparam int CNT_W = 8;
  localparam int NV    = 27;

  logic             clkin = 1'b0;
  logic             rst   = 1'b1;
  logic             sigin = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             locked;
  logic             timeout;

  clock_period_meter #(.CNT_W(CNT_W), .TOL(1), .LOCK_N(4)) dut (
    .clkin     (clkin),
    .rst       (rst),
    .sigin     (sigin),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clkin = ~clkin;

  int cyc = 0;
  int vcount = 0;
  int errors = 0;
  int checks = 0;
  int last_rise_cyc = 0;
  int v_p [64];
  int v_h [64];
  int v_l [64];
  int v_c [64];

  int exp_p [NV] = '{4,4,4,4,4, 4,10,13,10,13, 10,8,8,8,8,8, 8,9,9,9, 5,5,4,4,4,4,4};
  int exp_h [NV] = '{2,2,2,2,2, 2,5,5,5,5,    5,4,4,4,4,4,  4,4,4,4, 2,2,2,2,2,2,2};
  int exp_l [NV] = '{0,0,0,0,1, 1,0,0,0,0,    0,0,0,0,0,1,  1,1,1,1, 0,0,0,0,1,1,1};

  always @(posedge clkin) begin
    cyc = cyc + 1;
    #1;
    if (valid === 1'b1) begin
      if (vcount < 64) begin
        v_p[vcount] = int'(period);
        v_h[vcount] = int'(high_time);
        v_l[vcount] = int'(locked);
        v_c[vcount] = cyc;
      end
      vcount = vcount + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      @(negedge clkin);
      if (i == 0) last_rise_cyc = cyc;
      sigin = 1'b1;
    end
    for (int i = 0; i < lo; i++) begin
      @(negedge clkin);
      sigin = 1'b0;
    end
  endtask

  initial begin
    int r2;
    int n;
    int vc0;

    rst = 1'b1;
    sigin = 1'b0;
    repeat (3) @(negedge clkin);
    chk("reset_period", 32'(period), 0);
    chk("reset_high", 32'(high_time), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_locked", 32'(locked), 0);
    chk("reset_timeout", 32'(timeout), 0);
    @(negedge clkin);
    rst = 1'b0;
    repeat (2) @(negedge clkin);

    r2 = 0;
    for (int k = 0; k < 6; k++) begin
      drive(2, 2);
      if (k == 1) r2 = last_rise_cyc;
    end
    chk("div4_valid_count", 32'(vcount), 5);
    chk("first_valid_latency", 32'(v_c[0]), 32'(r2 + 3));

    drive(5, 5);
    drive(5, 8);
    drive(5, 5);
    drive(5, 8);
    drive(5, 5);
    chk("alt_valid_count", 32'(vcount), 10);

    for (int k = 0; k < 6; k++) drive(4, 4);
    for (int k = 0; k < 3; k++) drive(4, 5);
    chk("tol_valid_count", 32'(vcount), 19);

    @(negedge clkin);
    n = cyc;
    sigin = 1'b1;
    @(negedge clkin);
    sigin = 1'b0;
    while (cyc < n + 257) @(negedge clkin);
    chk("timeout_not_yet", 32'(timeout), 0);
    @(negedge clkin);
    chk("timeout_set", 32'(timeout), 1);
    chk("timeout_locked", 32'(locked), 0);
    chk("timeout_no_valid", 32'(vcount), 20);

    drive(2, 3);
    chk("timeout_cleared", 32'(timeout), 0);
    chk("idle_rise_no_valid", 32'(vcount), 20);
    drive(2, 3);
    chk("valid_after_timeout", 32'(vcount), 21);
    for (int k = 0; k < 6; k++) drive(2, 2);
    chk("relock_valid_count", 32'(vcount), NV);

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("period[%0d]", i), 32'(v_p[i]), 32'(exp_p[i]));
      chk($sformatf("high_time[%0d]", i), 32'(v_h[i]), 32'(exp_h[i]));
      chk($sformatf("locked[%0d]", i), 32'(v_l[i]), 32'(exp_l[i]));
    end

    @(negedge clkin);
    sigin = 1'b1;
    @(negedge clkin);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_period", 32'(period), 0);
    chk("async_rst_high", 32'(high_time), 0);
    chk("async_rst_valid", 32'(valid), 0);
    chk("async_rst_locked", 32'(locked), 0);
    chk("async_rst_timeout", 32'(timeout), 0);
    @(negedge clkin);
    rst = 1'b0;
    sigin = 1'b0;
    repeat (3) @(negedge clkin);
    vc0 = vcount;
    drive(2, 2);
    chk("post_rst_first_rise", 32'(vcount), 32'(vc0));
    drive(2, 2);
    chk("post_rst_valid", 32'(vcount), 32'(vc0 + 1));
    chk("post_rst_period", 32'(v_p[vc0]), 4);

    @(negedge clkin);
    rst = 1'b1;
    sigin = 1'b1;
    repeat (2) @(negedge clkin);
    rst = 1'b0;
    vc0 = vcount;
    repeat (100) @(negedge clkin);
    chk("const_high_no_valid", 32'(vcount), 32'(vc0));
    chk("const_high_timeout", 32'(timeout), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
